limn2600_tagged_cache: RTL and testbench
========================================

# limn2600_tagged_cache

Parametrised direct-mapped, tagged, write-through cache for the Limn2600 core, sitting between a CPU load/store port and the memory bus. Unlike the untagged hash-indexed store it supersedes, it detects hits and misses, refills multi-word lines from memory over a valid/ready handshake, and supports bulk invalidation. It also provides saturating hit/miss statistics.

## Interface
- DATA_WIDTH, 32, word width in bits
- ADDR_WIDTH, 32, word address width; no byte addressing
- INDEX_BITS, 8, number of lines = 2^INDEX_BITS
- OFFSET_BITS, 2, words per line = 2^OFFSET_BITS; tag = ADDR_WIDTH-INDEX_BITS-OFFSET_BITS bits

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  CPU request valid
- req_ready  out  1  cache can accept; = (state==IDLE) && !inv_all
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  word address
- req_wdata  in  DATA_WIDTH  write data
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  DATA_WIDTH  read data; 0 for writes
- inv_all  in  1  invalidate all lines (sampled in IDLE)
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_we  out  1  memory write
- mem_addr  out  ADDR_WIDTH  memory word address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_resp_valid  in  1  read data returned
- mem_resp_rdata  in  DATA_WIDTH  read data
- stat_hits  out  32  saturating hit counter
- stat_misses  out  32  saturating miss counter

## Operation
- Storage: data array of 2^(INDEX_BITS+OFFSET_BITS) words, tag array of 2^INDEX_BITS entries, and a valid flop vector of 2^INDEX_BITS bits.
- States: IDLE, LOOKUP, REFILL, WRITE, RESP.
- IDLE:
  - inv_all=1: clear all valid bits in that cycle and stay in IDLE; takes priority over req_valid.
  - Else, on req_valid && req_ready: latch we/addr/wdata, read arrays, go to LOOKUP.
- LOOKUP: hit = valid[index] && tag match.
  - Read hit: register word, stat_hits++, go to RESP.
  - Read miss: stat_misses++, go to REFILL with word counter 0.
  - Write: stat_hits++ or stat_misses++ as appropriate. On hit, update the data word. Write-through, no-allocate: go to WRITE.
- REFILL: for k = 0..2^OFFSET_BITS-1:
  - Drive mem_req_valid=1, mem_we=0, mem_addr={tag,index,k} until mem_req_ready.
  - Then wait for mem_resp_valid; write the word to the data array; capture it as resp_rdata if k == requested offset.
  - One outstanding request at a time.
  - After the last word: tag[index]=tag, valid[index]=1, go to RESP.
- WRITE: drive mem_req_valid=1, mem_we=1, mem_addr=req addr, mem_wdata until mem_req_ready; then go to RESP. No memory response is expected.
- RESP: resp_valid=1 for one cycle, then IDLE. resp_rdata holds until the next response.
- mem_resp_valid outside an outstanding REFILL read is ignored.
- Statistics saturate at 32'hFFFF_FFFF. They are not cleared by inv_all.

## Timing
- Reset values: req_ready=0 during rst, 1 in the cycle after; resp_valid=0; resp_rdata=0; mem_req_valid=0; mem_we=0; mem_addr=0; mem_wdata=0; stats=0; all valid bits=0; state=IDLE.
- rst mid-refill or mid-write: abort to IDLE immediately and drop the pending line (valid stays 0). Late mem responses are ignored.
- Read hit: accepted at edge T; resp_valid high in the cycle after edge T+2. Issue rate is one request per 3 cycles.
- Read miss: resp_valid follows one cycle after the last refill word is captured.
- Write: resp_valid one cycle after the mem_req_valid && mem_req_ready handshake.
- A read issued immediately after a completed write to the same address returns the new data if the line was resident. Otherwise it misses and refills from memory.
- The mem_req_valid/mem_addr/mem_we/mem_wdata bundle is stable while mem_req_valid=1 && !mem_req_ready.

## Test plan
All scenarios use INDEX_BITS=2, OFFSET_BITS=1, and a memory model where mem[a] = a ^ 32'hA5A5_0000 with 0–3 cycle random ready/response delays.
- Reset, then read 0x11 -> 2 mem reads at 0x10, 0x11; resp_rdata=0xA5A5_0011; stat_misses=1.
- Repeat read 0x10 -> hit, no mem traffic, resp_rdata=0xA5A5_0010, resp_valid at the third cycle; stat_hits=1.
- Write 0x11 <- 0xDEAD_BEEF -> one mem write (mem_we=1, addr 0x11); then read 0x11 -> hit returning 0xDEAD_BEEF. Write 0x31 (miss) -> mem write only; a subsequent read 0x11 still hits.
- Read 0x19 after 0x11 (same index, new tag) -> evicting refill, then read 0x11 misses again.
- Assert inv_all together with req_valid -> req_ready=0 that cycle; the next read of 0x10 misses.
- Assert rst during REFILL after the first word -> mem_req_valid=0 next cycle; stray mem_resp_valid ignored; the next read of 0x10 misses and refills.

Source files
------------

// File: rtl/limn2600_tagged_cache.sv
// Direct-mapped, tagged, write-through (no-allocate) cache for the Limn2600 load/store port.
// Lines are refilled one word at a time over the memory valid/ready handshake.
module limn2600_tagged_cache #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int INDEX_BITS  = 8,
    parameter int OFFSET_BITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    input  logic                  inv_all,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_rdata,
    output logic [31:0]           stat_hits,
    output logic [31:0]           stat_misses
);
    localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int WORDS    = 1 << (INDEX_BITS + OFFSET_BITS);

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_REFILL, S_WRITE, S_RESP} state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [DATA_WIDTH-1:0] data_mem [WORDS];
    logic [TAG_BITS-1:0]   tag_mem  [LINES];

    state_t                state_q, state_d;
    logic [LINES-1:0]      valid_q, valid_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic [OFFSET_BITS-1:0] cnt_q, cnt_d, cnt_nxt;
    logic                  wait_q, wait_d;
    logic                  mem_req_valid_q, mem_req_valid_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic [31:0]           hits_q, hits_d, misses_q, misses_d;
    logic [DATA_WIDTH-1:0] data_rd_q;
    logic [TAG_BITS-1:0]   tag_rd_q;

    logic                  data_we, tag_we, accept, hit;
    logic [INDEX_BITS+OFFSET_BITS-1:0] data_waddr;
    logic [DATA_WIDTH-1:0] data_wval;
    logic [TAG_BITS-1:0]   req_tag;
    logic [INDEX_BITS-1:0] req_idx;
    logic [OFFSET_BITS-1:0] req_off;

    assign req_tag = addr_q[ADDR_WIDTH-1 -: TAG_BITS];
    assign req_idx = addr_q[OFFSET_BITS +: INDEX_BITS];
    assign req_off = addr_q[OFFSET_BITS-1:0];
    assign hit     = valid_q[req_idx] && (tag_rd_q == req_tag);
    assign cnt_nxt = cnt_q + 1'b1;

    assign req_ready = (state_q == S_IDLE) && !inv_all && !rst;
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d         = state_q;
        valid_d         = valid_q;
        we_d            = we_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        word_d          = word_q;
        cnt_d           = cnt_q;
        wait_d          = wait_q;
        mem_req_valid_d = mem_req_valid_q;
        mem_we_d        = mem_we_q;
        mem_addr_d      = mem_addr_q;
        mem_wdata_d     = mem_wdata_q;
        resp_valid_d    = 1'b0;
        resp_rdata_d    = resp_rdata_q;
        hits_d          = hits_q;
        misses_d        = misses_q;
        data_we         = 1'b0;
        data_waddr      = {req_idx, req_off};
        data_wval       = wdata_q;
        tag_we          = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (inv_all) begin
                    valid_d = '0;
                end else if (accept) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (hit) hits_d = sat_inc(hits_q);
                else     misses_d = sat_inc(misses_q);
                if (we_q) begin
                    // Write-through: hits update in place, misses never allocate.
                    word_d          = '0;
                    data_we         = hit;
                    mem_req_valid_d = 1'b1;
                    mem_we_d        = 1'b1;
                    mem_addr_d      = addr_q;
                    mem_wdata_d     = wdata_q;
                    state_d         = S_WRITE;
                end else if (hit) begin
                    word_d  = data_rd_q;
                    state_d = S_RESP;
                end else begin
                    cnt_d           = '0;
                    wait_d          = 1'b0;
                    mem_req_valid_d = 1'b1;
                    mem_we_d        = 1'b0;
                    mem_addr_d      = {req_tag, req_idx, {OFFSET_BITS{1'b0}}};
                    state_d         = S_REFILL;
                end
            end
            S_REFILL: begin
                if (!wait_q) begin
                    if (mem_req_ready) begin
                        mem_req_valid_d = 1'b0;
                        wait_d          = 1'b1;
                    end
                end else if (mem_resp_valid) begin
                    data_we    = 1'b1;
                    data_waddr = {req_idx, cnt_q};
                    data_wval  = mem_resp_rdata;
                    wait_d     = 1'b0;
                    if (cnt_q == req_off) word_d = mem_resp_rdata;
                    if (cnt_q == {OFFSET_BITS{1'b1}}) begin
                        tag_we           = 1'b1;
                        valid_d[req_idx] = 1'b1;
                        state_d          = S_RESP;
                    end else begin
                        cnt_d           = cnt_nxt;
                        mem_req_valid_d = 1'b1;
                        mem_addr_d      = {req_tag, req_idx, cnt_nxt};
                    end
                end
            end
            S_WRITE: begin
                if (mem_req_ready) begin
                    mem_req_valid_d = 1'b0;
                    mem_we_d        = 1'b0;
                    state_d         = S_RESP;
                end
            end
            S_RESP: begin
                resp_valid_d = 1'b1;
                resp_rdata_d = word_q;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            valid_q         <= '0;
            cnt_q           <= '0;
            wait_q          <= 1'b0;
            mem_req_valid_q <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            resp_valid_q    <= 1'b0;
            resp_rdata_q    <= '0;
            hits_q          <= '0;
            misses_q        <= '0;
        end else begin
            state_q         <= state_d;
            valid_q         <= valid_d;
            cnt_q           <= cnt_d;
            wait_q          <= wait_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_we_q        <= mem_we_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            resp_valid_q    <= resp_valid_d;
            resp_rdata_q    <= resp_rdata_d;
            hits_q          <= hits_d;
            misses_q        <= misses_d;
        end
    end

    always_ff @(posedge clk) begin
        we_q    <= we_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        word_q  <= word_d;
    end

    // Arrays are read on accept so LOOKUP sees registered tag/data (RAM-friendly).
    always_ff @(posedge clk) begin
        if (data_we && !rst) data_mem[data_waddr] <= data_wval;
        if (tag_we && !rst)  tag_mem[req_idx] <= req_tag;
        if (accept) begin
            data_rd_q <= data_mem[req_addr[INDEX_BITS+OFFSET_BITS-1:0]];
            tag_rd_q  <= tag_mem[req_addr[OFFSET_BITS +: INDEX_BITS]];
        end
    end

    assign resp_valid    = resp_valid_q;
    assign resp_rdata    = resp_rdata_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign stat_hits     = hits_q;
    assign stat_misses   = misses_q;

endmodule

// File: tb/tb_limn2600_tagged_cache.sv
// Bench for limn2600_tagged_cache: directed scenarios plus random traffic against a
// line-level cache model and a write-through memory with random handshake delays.
module tb_limn2600_tagged_cache;
    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        inv_all;
    logic        mem_req_valid, mem_req_ready, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;
    logic [31:0] stat_hits, stat_misses;

    always #5 clk = ~clk;

    limn2600_tagged_cache #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .INDEX_BITS(2), .OFFSET_BITS(1)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .inv_all(inv_all),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .stat_hits(stat_hits), .stat_misses(stat_misses)
    );

    typedef struct packed { logic we; logic [31:0] addr; logic [31:0] wdata; } mreq_t;
    mreq_t       log_q[$];
    logic [31:0] mem_store [logic [31:0]];
    int unsigned vec_cnt = 0, err_cnt = 0;
    int unsigned rd_resp_cnt = 0;
    int unsigned stray_req_n = 0;

    // Reference cache: 4 lines of 2 words, tag = addr[31:3], index = addr[2:1].
    logic        m_valid [4];
    logic [28:0] m_tag   [4];
    logic [31:0] m_data  [8];
    logic [31:0] m_hits, m_misses;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (mem_store.exists(a)) return mem_store[a];
        return a ^ K;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
        m_hits = 0;
        m_misses = 0;
    endtask

    // Memory side: random ready delay, then (for reads) random response delay.
    initial begin : mem_side
        logic [31:0] a, wd;
        logic        w, hs;
        int          d;
        int unsigned stray_done = 0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
        forever begin
            @(negedge clk);
            mem_resp_valid = 1'b0;
            if (stray_req_n != stray_done) begin
                stray_done = stray_req_n;
                mem_resp_valid = 1'b1;
                mem_resp_rdata = 32'h5555_AAAA;
            end else if (mem_req_valid && !rst) begin
                a = mem_addr; w = mem_we; wd = mem_wdata;
                d = $urandom_range(0, 3);
                for (int i = 0; i < d; i++) begin
                    @(negedge clk);
                    if (mem_req_valid && !rst) begin
                        chk("mem_addr_stable", mem_addr, a);
                        chk("mem_we_stable", 32'(mem_we), 32'(w));
                        chk("mem_wdata_stable", mem_wdata, wd);
                    end
                end
                mem_req_ready = 1'b1;
                hs = mem_req_valid && !rst;
                @(negedge clk);
                mem_req_ready = 1'b0;
                if (hs) begin
                    log_q.push_back('{we: w, addr: a, wdata: wd});
                    if (w) mem_store[a] = wd;
                    else begin
                        d = $urandom_range(0, 3);
                        repeat (d) @(negedge clk);
                        mem_resp_valid = 1'b1;
                        mem_resp_rdata = mem_val(a);
                        rd_resp_cnt++;
                    end
                end
            end
        end
    end

    task automatic do_inv();
        inv_all = 1'b1;
        @(negedge clk);
        chk("ready_during_inv", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        inv_all = 1'b0;
        for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
    endtask

    task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic inv_first);
        logic [31:0] exp_rd, base;
        logic        hit, acc, seen;
        int          idx, lat, exp_n;
        logic [28:0] tg;
        idx = int'(a[2:1]);
        tg  = a[31:3];
        base = {a[31:1], 1'b0};
        log_q.delete();
        req_we = we; req_addr = a; req_wdata = wd;
        if (inv_first) begin
            inv_all = 1'b1; req_valid = 1'b1;
            @(negedge clk);
            chk("ready_inv_with_req", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
            inv_all = 1'b0;
            for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
        end
        hit = m_valid[idx] && (m_tag[idx] == tg);
        if (hit) m_hits++; else m_misses++;
        exp_n = 0;
        if (we) begin
            exp_rd = '0;
            exp_n = 1;
            if (hit) m_data[a[2:0]] = wd;
        end else if (hit) begin
            exp_rd = m_data[a[2:0]];
        end else begin
            exp_rd = mem_val(a);
            exp_n = 2;
            m_data[{a[2:1], 1'b0}] = mem_val(base);
            m_data[{a[2:1], 1'b1}] = mem_val(base | 32'd1);
            m_valid[idx] = 1'b1;
            m_tag[idx] = tg;
        end
        req_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk); #1;
            if (acc) break;
        end
        req_valid = 1'b0;
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
        seen = 1'b0; lat = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (resp_valid) begin seen = 1'b1; lat = i; break; end
        end
        chk("resp_seen", 32'(seen), 32'd1);
        if (seen) begin
            chk(we ? "wr_resp_rdata" : "rd_resp_rdata", resp_rdata, exp_rd);
            if (!we && hit) chk("hit_latency", 32'(lat), 32'd3);
            chk("mem_txn_count", 32'(log_q.size()), 32'(exp_n));
            if (log_q.size() == exp_n) begin
                if (we) begin
                    chk("mem_wr_we", 32'(log_q[0].we), 32'd1);
                    chk("mem_wr_addr", log_q[0].addr, a);
                    chk("mem_wr_data", log_q[0].wdata, wd);
                end else if (!hit) begin
                    chk("refill0_we", 32'(log_q[0].we), 32'd0);
                    chk("refill0_addr", log_q[0].addr, base);
                    chk("refill1_addr", log_q[1].addr, base | 32'd1);
                end
            end
            chk("stat_hits", stat_hits, m_hits);
            chk("stat_misses", stat_misses, m_misses);
            @(negedge clk);
            chk("resp_one_pulse", 32'(resp_valid), 32'd0);
        end
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic        seen, any_resp;
        int unsigned base_cnt;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; inv_all = 1'b0;
        for (int i = 0; i < 8; i++) m_data[i] = '0;
        for (int i = 0; i < 4; i++) m_tag[i] = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_stat_hits", stat_hits, 32'd0);
        chk("rst_stat_misses", stat_misses, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(req_ready), 32'd1);
        @(posedge clk); #1;

        do_req(1'b0, 32'h11, '0, 1'b0);
        do_req(1'b0, 32'h10, '0, 1'b0);
        do_req(1'b1, 32'h11, 32'hDEAD_BEEF, 1'b0);
        do_req(1'b0, 32'h11, '0, 1'b0);
        do_req(1'b1, 32'h31, 32'h1234_5678, 1'b0);
        do_req(1'b0, 32'h11, '0, 1'b0);
        do_req(1'b0, 32'h19, '0, 1'b0);
        do_req(1'b0, 32'h11, '0, 1'b0);
        do_req(1'b0, 32'h10, '0, 1'b1);

        // Reset in the middle of a refill, after its first word has landed.
        do_inv();
        base_cnt = rd_resp_cnt;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_wdata = '0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (rd_resp_cnt != base_cnt) begin seen = 1'b1; break; end
        end
        chk("refill_word0_seen", 32'(seen), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk("abort_mem_req_valid", 32'(mem_req_valid), 32'd0);
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        chk("abort_stat_misses", stat_misses, 32'd0);
        @(posedge clk); #1;
        stray_req_n++;
        any_resp = 1'b0;
        repeat (4) begin
            @(negedge clk);
            any_resp = any_resp | resp_valid;
        end
        chk("stray_resp_ignored", 32'(any_resp), 32'd0);
        @(posedge clk); #1;
        do_req(1'b0, 32'h10, '0, 1'b0);

        for (int n = 0; n < 150; n++) begin
            int unsigned r;
            r = $urandom_range(0, 11);
            if (r == 0) do_inv();
            else do_req(($urandom_range(0, 2) == 0), 32'($urandom_range(0, 63)), $urandom, (r == 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
